// File: rtl/mem_io_responder_pkg.sv
// Shared constants and access decode for the CPU-side RAM/IO responder.
// IO space is selected by address bits [17:16] == 2'b11.
package mem_io_responder_pkg;

    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [7:0]  STOP_BYTE    = 8'h00;

    typedef enum logic [1:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_IO_RD,
        ACC_IO_WR
    } access_t;

    function automatic access_t decode_access(input logic [17:0] addr, input logic wr);
        if (addr[17:16] == IO_SEL) return wr ? ACC_IO_WR : ACC_IO_RD;
        return wr ? ACC_RAM_WR : ACC_RAM_RD;
    endfunction

endpackage

// File: rtl/mem_io_responder_tx_byte_fifo.sv
// Power-of-two byte FIFO feeding the UART transmitter; head is read combinationally.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module mem_io_responder_tx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic                       dropped,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign dropped  = push && !push_ok;
    assign pop_data = storage[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// RAM/IO responder on the CPU byte bus: RAM with 1-cycle reads, UART TX FIFO, cycle counter, program stop.
// Optional UART receive holder at 0x30000 is built when RESPONDER_RX_EN is defined.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overflow,
    output logic        program_stop
`ifdef RESPONDER_RX_EN
    ,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`endif
);

    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(TX_DEPTH - FULL_MARGIN);

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [17:0]           io_addr;
    access_t               acc;
    logic [31:0]           counter;
    logic [31:0]           snapshot;
    logic [7:0]            io_rdata;
    logic [7:0]            rx_rdata;
    logic                  push;
    logic [7:0]            push_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_dropped;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_next;
    logic                  unused_addr_bits;

    assign ram_addr         = mem_a[ADDR_WIDTH-1:0];
    assign io_addr          = mem_a[17:0];
    assign acc              = decode_access(io_addr, mem_wr);
    assign unused_addr_bits = &{1'b0, mem_a[31:18], fifo_full, fifo_count};

    // Only 0x30000 (nonzero data) and 0x30004 (stop marker) feed the transmitter.
    always_comb begin
        push      = 1'b0;
        push_data = mem_dout;
        if (!rst_in && acc == ACC_IO_WR) begin
            if (io_addr == IO_DATA_ADDR) begin
                push = (mem_dout != 8'h00);
            end else if (io_addr == IO_CLK_ADDR) begin
                push      = 1'b1;
                push_data = STOP_BYTE;
            end
        end
    end

    mem_io_responder_tx_byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (push),
        .push_data  (push_data),
        .pop        (tx_ready),
        .pop_data   (tx_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .dropped    (fifo_dropped),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    assign tx_valid = !fifo_empty;

    always_comb begin
        io_rdata = 8'h00;
        case (io_addr)
            IO_DATA_ADDR:          io_rdata = rx_rdata;
            IO_CLK_ADDR:           io_rdata = counter[7:0];
            IO_CLK_ADDR + 18'd1:   io_rdata = snapshot[15:8];
            IO_CLK_ADDR + 18'd2:   io_rdata = snapshot[23:16];
            IO_CLK_ADDR + 18'd3:   io_rdata = snapshot[31:24];
            default:               io_rdata = 8'h00;
        endcase
    end

    // RAM contents survive reset; no access is performed while reset is held.
    always_ff @(posedge clk_in) begin
        if (!rst_in && acc == ACC_RAM_WR) ram[ram_addr] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din        <= 8'h00;
            counter        <= '0;
            snapshot       <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_stop   <= 1'b0;
        end else begin
            case (acc)
                ACC_RAM_RD: mem_din <= ram[ram_addr];
                ACC_IO_RD:  mem_din <= io_rdata;
                default:    mem_din <= mem_din;
            endcase
            if (acc == ACC_IO_RD && io_addr == IO_CLK_ADDR) snapshot <= counter;
            if (acc == ACC_IO_WR && io_addr == IO_CLK_ADDR) program_stop <= 1'b1;
            if (fifo_dropped) tx_overflow <= 1'b1;
            counter        <= counter + 32'd1;
            io_buffer_full <= (fifo_count_next >= FULL_LEVEL);
        end
    end

`ifdef RESPONDER_RX_EN
    logic       rx_held;
    logic [7:0] rx_byte;
    logic       rx_load;
    logic       rx_take;

    assign rx_ready = !rx_held;
    assign rx_load  = rx_valid && !rx_held;
    assign rx_take  = (acc == ACC_IO_RD) && (io_addr == IO_DATA_ADDR);
    assign rx_rdata = rx_held ? rx_byte : 8'h00;

    // A load only happens into an empty holder, so it never collides with a take of a held byte.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_held <= 1'b0;
        end else if (rx_load) begin
            rx_held <= 1'b1;
        end else if (rx_take) begin
            rx_held <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rx_load) rx_byte <= rx_data;
    end
`else
    assign rx_rdata = 8'h00;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a queue/array reference model checked every cycle.
// Define RESPONDER_RX_EN for both bench and RTL to exercise the receive holder.
module tb_mem_io_responder;

    localparam int TX_DEPTH   = 8;
    localparam int FULL_LEVEL = 6;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_overflow;
    logic        program_stop;
`ifdef RESPONDER_RX_EN
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
`endif

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_overflow    (tx_overflow),
        .program_stop   (program_stop)
`ifdef RESPONDER_RX_EN
        ,
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
`endif
    );

    // Reference model state
    logic [7:0]  m_ram [logic [16:0]];
    logic [7:0]  m_q [$];
    logic [7:0]  m_din;
    logic        m_ovf;
    logic        m_stop;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_held;
    logic [7:0]  m_hbyte;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [17:0] a;
        logic        io;
        logic        pop;
        logic        has_push;
        logic [7:0]  pbyte;
        logic        old_held;
        if (rst_in) begin
            m_q.delete();
            m_din  = 8'h00;
            m_ovf  = 1'b0;
            m_stop = 1'b0;
            m_cnt  = 32'd0;
            m_snap = 32'd0;
            m_held = 1'b0;
            return;
        end
        a        = mem_a[17:0];
        io       = (a[17:16] == 2'b11);
        pop      = (m_q.size() != 0) && tx_ready;
        has_push = 1'b0;
        pbyte    = 8'h00;
        old_held = m_held;
        if (mem_wr) begin
            if (!io) begin
                m_ram[mem_a[16:0]] = mem_dout;
            end else if (a == 18'h30000) begin
                if (mem_dout != 8'h00) begin
                    has_push = 1'b1;
                    pbyte    = mem_dout;
                end
            end else if (a == 18'h30004) begin
                has_push = 1'b1;
                pbyte    = 8'h00;
                m_stop   = 1'b1;
            end
        end else if (!io) begin
            m_din = m_ram.exists(mem_a[16:0]) ? m_ram[mem_a[16:0]] : 8'hxx;
        end else begin
            case (a)
                18'h30004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                18'h30005: m_din = m_snap[15:8];
                18'h30006: m_din = m_snap[23:16];
                18'h30007: m_din = m_snap[31:24];
`ifdef RESPONDER_RX_EN
                18'h30000: begin m_din = m_held ? m_hbyte : 8'h00; m_held = 1'b0; end
`endif
                default:   m_din = 8'h00;
            endcase
        end
`ifdef RESPONDER_RX_EN
        if (rx_valid && !old_held) begin
            m_held  = 1'b1;
            m_hbyte = rx_data;
        end
`endif
        if (pop) void'(m_q.pop_front());
        if (has_push) begin
            if (m_q.size() < TX_DEPTH) m_q.push_back(pbyte);
            else m_ovf = 1'b1;
        end
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic compare_all();
        check("mem_din", mem_din, m_din);
        check("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
        check("io_buffer_full", io_buffer_full, m_q.size() >= FULL_LEVEL);
        check("tx_overflow", tx_overflow, m_ovf);
        check("program_stop", program_stop, m_stop);
`ifdef RESPONDER_RX_EN
        check("rx_ready", rx_ready, !m_held);
`endif
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr   = wr;
        mem_a    = a;
        mem_dout = d;
        cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        drive(1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b0, a, 8'h00);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0003_000C, 8'h00);
    endtask

    initial begin
        rst_in   = 1'b1;
        mem_wr   = 1'b0;
        mem_a    = 32'h0003_000C;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
`ifdef RESPONDER_RX_EN
        rx_valid = 1'b0;
        rx_data  = 8'h00;
`endif
        cyc();
        cyc();
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_io_full", io_buffer_full, 1'b0);
        check("rst_stop", program_stop, 1'b0);
        rst_in = 1'b0;

        // Cycle counter: the 101st cycle after reset release sees 100.
        repeat (100) idle();
        rd(32'h0003_0004);
        check("clk_byte0", mem_din, 8'h64);
        rd(32'h0003_0005);
        check("clk_byte1", mem_din, 8'h00);
        rd(32'h0003_0006);
        rd(32'h0003_0007);
        check("clk_byte3", mem_din, 8'h00);

        // RAM write/read; writes hold mem_din; upper address bits ignored.
        wr(32'h0000_0020, 8'h5A);
        rd(32'h0000_0020);
        check("ram_rd_5a", mem_din, 8'h5A);
        wr(32'h0000_0010, 8'hA5);
        check("wr_holds_din", mem_din, 8'h5A);
        rd(32'hABC0_0010);
        check("ram_rd_a5", mem_din, 8'hA5);
        wr(32'h0001_0010, 8'hC3);
        rd(32'h0001_0010);
        check("ram_rd_hi", mem_din, 8'hC3);
        wr(32'h0003_0008, 8'h11);
        rd(32'h0003_0000);
        check("io_data_rd", mem_din, 8'h00);
        check("io_other_wr", tx_valid, 1'b0);

        // TX path: zero bytes filtered at 0x30000.
        wr(32'h0003_0000, 8'h48);
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0000, 8'h69);
        check("tx_head_48", tx_data, 8'h48);
        tx_ready = 1'b1;
        idle();
        check("tx_head_69", tx_data, 8'h69);
        idle();
        check("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Near-full threshold, overflow, push+pop at full.
        for (int i = 1; i <= 5; i++) wr(32'h0003_0000, 8'(i));
        check("io_full_5", io_buffer_full, 1'b0);
        wr(32'h0003_0000, 8'h06);
        check("io_full_6", io_buffer_full, 1'b1);
        wr(32'h0003_0000, 8'h07);
        wr(32'h0003_0000, 8'h08);
        check("no_ovf_8", tx_overflow, 1'b0);
        wr(32'h0003_0000, 8'h09);
        check("ovf_9", tx_overflow, 1'b1);
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h0A);
        check("full_pushpop_head", tx_data, 8'h02);
        tx_ready = 1'b0;
        idle();
        tx_ready = 1'b1;
        repeat (8) idle();
        check("full_drained", tx_valid, 1'b0);
        check("ovf_sticky", tx_overflow, 1'b1);
        tx_ready = 1'b0;
        rst_in = 1'b1;
        idle();
        rst_in = 1'b0;
        check("ovf_cleared", tx_overflow, 1'b0);

        // Program stop pushes the stop marker and stays set until reset.
        wr(32'h0003_0004, 8'h77);
        check("stop_set", program_stop, 1'b1);
        check("stop_byte", tx_data, 8'h00);
        wr(32'h0003_0000, 8'h41);
        wr(32'h0003_0000, 8'h42);
        repeat (3) idle();
        check("stop_sticky", program_stop, 1'b1);
        tx_ready = 1'b1;
        idle();
        check("mid_drain_head", tx_data, 8'h41);
        rst_in = 1'b1;
        idle();
        rst_in = 1'b0;
        tx_ready = 1'b0;
        check("rst_flush", tx_valid, 1'b0);
        check("rst_stop_clr", program_stop, 1'b0);
        idle();

`ifdef RESPONDER_RX_EN
        rx_data  = 8'h37;
        rx_valid = 1'b1;
        idle();
        rx_valid = 1'b0;
        check("rx_busy", rx_ready, 1'b0);
        rd(32'h0003_0000);
        check("rx_rd_37", mem_din, 8'h37);
        check("rx_free", rx_ready, 1'b1);
        rd(32'h0003_0000);
        check("rx_rd_empty", mem_din, 8'h00);
        rx_data  = 8'h42;
        rx_valid = 1'b1;
        rd(32'h0003_0000);
        rx_valid = 1'b0;
        check("rx_same_cycle", mem_din, 8'h00);
        check("rx_kept", rx_ready, 1'b0);
        rd(32'h0003_0000);
        check("rx_rd_42", mem_din, 8'h42);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
